// File: rtl/cpu_exec_unit.sv
// Execute stage: decodes ir against the core's one-hot micro-step and owns the
// register file, flags, ALU, shift-add multiplier and output port.
module cpu_exec_unit #(
    parameter logic [1:0] ST_IE     = 2'd1,
    parameter int         MUL_STEPS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ir,
    input  logic [15:0] clks,
    input  logic [1:0]  state,
    output logic        inst_condition,
    output logic        end_inst,
    output logic        jmp_inst,
    output logic [7:0]  jmp_address,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        halted,
    output logic [2:0]  flags,
    input  logic [1:0]  dbg_sel,
    output logic [7:0]  dbg_data
);

    localparam logic [3:0] OP_LDI = 4'h1, OP_MOV = 4'h2, OP_ADD = 4'h3, OP_SUB = 4'h4,
                           OP_AND = 4'h5, OP_OR  = 4'h6, OP_XOR = 4'h7, OP_MUL = 4'h8,
                           OP_OUT = 4'h9, OP_CMP = 4'hA, OP_JMP = 4'hB, OP_SHL = 4'hC,
                           OP_SHR = 4'hD, OP_HLT = 4'hF;
    localparam logic [3:0] LAST_MUL = 4'(MUL_STEPS);
    localparam logic [3:0] FIN_MUL  = 4'(MUL_STEPS + 1);

    logic [7:0]  r_q [4];
    logic [2:0]  flags_q;          // {N,C,Z}
    logic [7:0]  ta_q, tb_q;
    logic [15:0] mcand_q, acc_q;
    logic [7:0]  mplier_q;
    logic [7:0]  out_data_q;
    logic        out_valid_q;

    logic [3:0]  op, cnd;
    logic [1:0]  rd, rs;
    logic [7:0]  imm;
    logic        ie, stp_vld, cond_ok, is_alu;
    logic [3:0]  stp, last_stp;
    logic [10:0] alu_d;
    logic [10:0] sh_d;

    // Returns {N,C,Z,result}; SUB/CMP carry is the borrow out of a 9-bit difference.
    function automatic logic [10:0] alu(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] t;
        case (o)
            OP_ADD:         t = {1'b0, a} + {1'b0, b};
            OP_SUB, OP_CMP: t = {1'b0, a} - {1'b0, b};
            OP_AND:         t = {1'b0, a & b};
            OP_OR:          t = {1'b0, a | b};
            default:        t = {1'b0, a ^ b};
        endcase
        return {t[7], t[8], t[7:0] == 8'h00, t[7:0]};
    endfunction

    function automatic logic [10:0] shifter(input logic left, input logic [7:0] a);
        logic [7:0] res;
        logic       c;
        res = left ? {a[6:0], 1'b0} : {1'b0, a[7:1]};
        c   = left ? a[7] : a[0];
        return {res[7], c, res == 8'h00, res};
    endfunction

    assign op  = ir[31:28];
    assign cnd = ir[27:24];
    assign rd  = ir[17:16];
    assign rs  = ir[9:8];
    assign imm = ir[7:0];
    assign ie  = (state == ST_IE);
    assign is_alu = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
                    (op == OP_OR)  || (op == OP_XOR) || (op == OP_CMP);

    always_comb begin
        stp     = 4'd0;
        stp_vld = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (clks == 16'(1 << k)) begin
                stp     = 4'(k);
                stp_vld = 1'b1;
            end
        end
    end

    always_comb begin
        case (cnd)
            4'd0:    cond_ok = 1'b1;
            4'd1:    cond_ok = flags_q[0];
            4'd2:    cond_ok = !flags_q[0];
            4'd3:    cond_ok = flags_q[1];
            4'd4:    cond_ok = !flags_q[1];
            4'd5:    cond_ok = flags_q[2];
            4'd6:    cond_ok = !flags_q[2];
            default: cond_ok = 1'b0;
        endcase
    end

    always_comb begin
        if (is_alu)            last_stp = 4'd1;
        else if (op == OP_MUL) last_stp = FIN_MUL;
        else                   last_stp = 4'd0;
    end

    assign alu_d = alu(op, ta_q, tb_q);
    assign sh_d  = shifter(op == OP_SHL, r_q[rd]);

    assign inst_condition = ie ? cond_ok : 1'b1;
    assign end_inst       = ie && stp_vld && (op != OP_HLT) && (stp == last_stp);
    assign jmp_inst       = ie && stp_vld && (stp == 4'd0) && (op == OP_JMP) && cond_ok;
    assign halted         = ie && (op == OP_HLT);
    assign jmp_address    = ir[7:0];
    assign out_data       = out_data_q;
    assign out_valid      = out_valid_q;
    assign flags          = flags_q;
    assign dbg_data       = r_q[dbg_sel];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) r_q[i] <= 8'h00;
            flags_q     <= 3'b000;
            ta_q        <= 8'h00;
            tb_q        <= 8'h00;
            mcand_q     <= 16'h0000;
            mplier_q    <= 8'h00;
            acc_q       <= 16'h0000;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (ie && stp_vld && cond_ok) begin
                if (stp == 4'd0) begin
                    case (op)
                        OP_LDI: r_q[rd] <= imm;
                        OP_MOV: r_q[rd] <= r_q[rs];
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_CMP: begin
                            ta_q <= r_q[rd];
                            tb_q <= r_q[rs];
                        end
                        OP_MUL: begin
                            mcand_q  <= {8'h00, r_q[rd]};
                            mplier_q <= r_q[rs];
                            acc_q    <= 16'h0000;
                        end
                        OP_OUT: begin
                            out_data_q  <= r_q[rs];
                            out_valid_q <= 1'b1;
                        end
                        OP_SHL, OP_SHR: begin
                            r_q[rd] <= sh_d[7:0];
                            flags_q <= sh_d[10:8];
                        end
                        default: ;
                    endcase
                end
                if (is_alu && stp == 4'd1) begin
                    if (op != OP_CMP) r_q[rd] <= alu_d[7:0];
                    flags_q <= alu_d[10:8];
                end
                if (op == OP_MUL && stp >= 4'd1 && stp <= LAST_MUL) begin
                    acc_q    <= acc_q + (mplier_q[0] ? mcand_q : 16'h0000);
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                end
                if (op == OP_MUL && stp == FIN_MUL) begin
                    r_q[rd] <= acc_q[7:0];
                    flags_q <= {acc_q[7], |acc_q[15:8], acc_q[7:0] == 8'h00};
                end
            end
        end
    end

endmodule

// File: doc/cpu_exec_unit.md
Name: cpu_exec_unit

Overview:
- Execute stage downstream of the fetch/sequencer core.
- Decodes the 32-bit instruction register using the core's one-hot micro-step counter and state.
- Owns the 4x8-bit register file, the Z/C/N flags, the ALU, a shift-add multiplier and an output port.
- Drives the inst_condition / end_inst / jmp_inst / jmp_address feedback that the core uses to advance or redirect the PC.

Parameters:
- ST_IE, 1, core state encoding for instruction execute.
- MUL_STEPS, 8, multiplier iterations (fixed for 8-bit operands).

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- ir  input  32  instruction: [31:28] opcode, [27:24] cond, [17:16] rd, [9:8] rs, [7:0] imm/address
- clks  input  16  one-hot micro-step from core (bit k = step k)
- state  input  2  core state
- inst_condition  output  1  predicate of current instruction
- end_inst  output  1  current step is the last step
- jmp_inst  output  1  taken jump
- jmp_address  output  8  jump target
- out_data  output  8  output port data
- out_valid  output  1  one-cycle strobe on OUT
- halted  output  1  HLT executing
- flags  output  3  {N,C,Z}
- dbg_sel  input  2  register select for debug read
- dbg_data  output  8  combinational read of R[dbg_sel]

Behaviour:
- Reset (async): R0-R3=0, flags=0, out_data=0, out_valid=0, multiplier/temp registers=0. A reset mid-instruction discards all partial state.
- "Active step k" = state==ST_IE && clks==bit k. Outside ST_IE: inst_condition=1, end_inst=0, jmp_inst=0, halted=0, no updates.
- Combinational outputs:
  - jmp_address = ir[7:0] always.
  - cond field: 0 AL, 1 EQ(Z), 2 NE(!Z), 3 CS(C), 4 CC(!C), 5 MI(N), 6 PL(!N), 7-15 never.
  - inst_condition is evaluated on current flags.
- Predication: if inst_condition=0, no register, flag or port update occurs and jmp_inst=0. The core then advances pc+1.
- All writes occur on the clk edge of the active step named below. end_inst is asserted during the final step, so writes and core return-to-fetch happen on the same edge.
- Opcodes (steps, end_inst step):
  - 0 NOP: 1 step, end CLK_0.
  - 1 LDI rd,imm: CLK_0 writes rd=imm; flags unchanged.
  - 2 MOV rd,rs: CLK_0 writes rd=rs; flags unchanged.
  - 3 ADD / 4 SUB / 5 AND / 6 OR / 7 XOR / A CMP:
    - CLK_0 latches TA=R[rd], TB=R[rs].
    - CLK_1 computes from TA,TB; writes rd (except CMP) and flags; end CLK_1.
    - ADD: C=carry out. SUB/CMP: C=borrow (TA<TB). Logic ops: C=0.
    - Z=(result==0), N=result[7].
  - 8 MUL rd,rs:
    - CLK_0 latches mcand16={0,R[rd]}, mplier=R[rs], acc16=0.
    - CLK_1..CLK_8, each step: if mplier[0] then acc+=mcand; then mcand<<=1, mplier>>=1.
    - CLK_9 writes rd=acc[7:0], Z=(acc[7:0]==0), C=|acc[15:8], N=acc[7]; end CLK_9.
    - Total 10 IE cycles. rd==rs is legal because operands are latched.
  - 9 OUT rs: CLK_0 writes out_data=R[rs]; out_valid=1 for exactly the following cycle; end CLK_0.
  - B JMP: jmp_inst=inst_condition; end CLK_0; no state change.
  - C SHL rd / D SHR rd: CLK_0 shifts in 0; C=bit shifted out; Z,N from result; end CLK_0.
  - E: reserved, behaves as NOP.
  - F HLT: end_inst held 0 and halted=1 while active, regardless of clks wrap.
- out_valid is a registered pulse and deasserts the next cycle unless another OUT executes.
- Flags update only on ADD/SUB/AND/OR/XOR/CMP/MUL/SHL/SHR.
- Skipped instructions still present end_inst per the table; the core ignores it.

Test Plan:
- LDI R1,0x05; LDI R2,0x03; ADD R1,R2 -> R1=0x08, flags Z=0 C=0 N=0, end_inst high only at CLK_1.
- LDI R0,0xFF; LDI R3,0x01; ADD R0,R3 -> R0=0x00, Z=1 C=1. Then JMP EQ 0x40 -> inst_condition=1, jmp_inst=1, jmp_address=0x40. JMP NE 0x40 -> inst_condition=0, jmp_inst=0.
- R1=0x0C, R2=0x15, MUL R1,R2 -> R1=0xFC, C=0, end_inst first at CLK_9 (10th IE cycle). Then 0x10*0x10 -> 0x00, Z=1, C=1.
- Start MUL, assert reset at CLK_4 -> R0-R3=0, flags=0, out_valid=0 immediately, without waiting for clk. After release, the next MUL gives the correct product.
- OUT R1 (R1=0xA5) -> out_data=0xA5, out_valid high for exactly 1 cycle. OUT with cond EQ while Z=0 -> no pulse, out_data unchanged.
- SUB: R2=0x03, R3=0x05, SUB R2,R3 -> R2=0xFE, C=1, N=1, Z=0. HLT -> halted=1, end_inst=0 for 20+ cycles across clks wrap.
